// File: rtl/alu_74181_sequencer.sv
`default_nettype none
// alu_74181_sequencer: drives one 4-bit 74181 slice nibble-serially, LSB first, chaining carry via G/P.
// Optional macro ALU_SEQ_BACK_TO_BACK_EN: accept a new request in the same cycle as the response handshake.
// Revision: 1.0
module alu_74181_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3:0]           req_s_i,
  input  logic                 req_m_i,
  input  logic                 req_carry_i,
  input  logic [4*NIBBLES-1:0] req_a_i,
  input  logic [4*NIBBLES-1:0] req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4*NIBBLES-1:0] rsp_f_o,
  output logic                 rsp_carry_o,
  output logic                 rsp_equal_o,
  output logic [3:0]           alu_s_o,
  output logic                 alu_m_o,
  output logic                 alu_carry_o,
  output logic [3:0]           alu_a_o,
  output logic [3:0]           alu_b_o,
  input  logic [3:0]           alu_f_i,
  input  logic                 alu_equal_i,
  input  logic                 alu_g_i,
  input  logic                 alu_p_i
);

  localparam int W  = 4*NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES-1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [KW-1:0] r_k;
  logic [3:0]    r_s;
  logic          r_m;
  logic          r_c;
  logic          r_eq;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_f;
  logic          w_req_hs;
  logic          w_rsp_hs;

  assign w_req_hs = req_valid_i & req_ready_o;
  assign w_rsp_hs = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A request handshake in DONE is only possible when back-to-back mode is built in.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_hs) w_next = ST_RUN;
      ST_RUN:  if (r_k == K_LAST) w_next = ST_DONE;
      ST_DONE: if (w_rsp_hs) w_next = w_req_hs ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    alu_s_o     = 4'd0;
    alu_m_o     = 1'b0;
    alu_carry_o = 1'b0;
    alu_a_o     = 4'd0;
    alu_b_o     = 4'd0;
    case (r_state)
      ST_IDLE: req_ready_o = ~rst_i;
      ST_RUN: begin
        alu_s_o     = r_s;
        alu_m_o     = r_m;
        alu_carry_o = r_c;
        alu_a_o     = r_a[4*r_k +: 4];
        alu_b_o     = r_b[4*r_k +: 4];
      end
      ST_DONE: begin
        rsp_valid_o = 1'b1;
`ifdef ALU_SEQ_BACK_TO_BACK_EN
        req_ready_o = rsp_ready_i & ~rst_i;
`else
        req_ready_o = 1'b0;
`endif
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k  <= '0;
      r_s  <= 4'd0;
      r_m  <= 1'b0;
      r_c  <= 1'b0;
      r_eq <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_f  <= '0;
    end else if (w_req_hs) begin
      r_k  <= '0;
      r_s  <= req_s_i;
      r_m  <= req_m_i;
      r_c  <= req_carry_i;
      r_eq <= 1'b1;
      r_a  <= req_a_i;
      r_b  <= req_b_i;
    end else if (r_state == ST_RUN) begin
      r_f[4*r_k +: 4] <= alu_f_i;
      r_eq            <= r_eq & alu_equal_i;
      r_c             <= r_m ? 1'b0 : (alu_g_i | (alu_p_i & r_c));
      if (r_k != K_LAST) r_k <= r_k + 1'b1;
    end
  end

  assign rsp_f_o     = r_f;
  assign rsp_carry_o = r_c;
  assign rsp_equal_o = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_alu_74181_sequencer.sv
`default_nettype none
// tb_alu_74181_sequencer: randomized self-checking bench with a 74181 slice model and a full-width reference.
module tb_alu_74181_sequencer;

  localparam int NIBBLES = 4;
  localparam int W = 4*NIBBLES;
`ifdef ALU_SEQ_BACK_TO_BACK_EN
  localparam int EXP_PERIOD = NIBBLES + 1;
`else
  localparam int EXP_PERIOD = NIBBLES + 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [3:0]   req_s;
  logic         req_m, req_carry;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_carry, rsp_equal;
  logic [3:0]   alu_s, alu_a, alu_b, alu_f;
  logic         alu_m, alu_carry, alu_eq, alu_g, alu_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_74181_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_s_i(req_s), .req_m_i(req_m), .req_carry_i(req_carry),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_f_o(rsp_f), .rsp_carry_o(rsp_carry), .rsp_equal_o(rsp_equal),
    .alu_s_o(alu_s), .alu_m_o(alu_m), .alu_carry_o(alu_carry),
    .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_f_i(alu_f), .alu_equal_i(alu_eq), .alu_g_i(alu_g), .alu_p_i(alu_p)
  );

  // 74181 logic-mode function table, active-high data.
  function automatic logic [W-1:0] logic_fn(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return '0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return '1;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // Full-width reference: arithmetic result is X + Y + carry over all W bits at once.
  function automatic logic [W:0] model(input logic [3:0] s, input logic m, input logic c,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    if (m) return {1'b0, logic_fn(s, a, b)};
    x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Combinational 4-bit slice.
  logic [3:0]   sl_x, sl_y;
  logic [4:0]   sl_sum, sl_nc;
  logic [W-1:0] sl_lf;
  always_comb begin
    sl_x   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    sl_y   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sl_nc  = {1'b0, sl_x} + {1'b0, sl_y};
    sl_sum = sl_nc + {4'b0, alu_carry};
    sl_lf  = logic_fn(alu_s, {{(W-4){1'b0}}, alu_a}, {{(W-4){1'b0}}, alu_b});
    alu_f  = alu_m ? sl_lf[3:0] : sl_sum[3:0];
    alu_g  = sl_nc[4];
    alu_p  = &sl_x;
    alu_eq = (alu_f == 4'hF);
  end

  task automatic send_req(input logic [3:0] s, input logic m, input logic c,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    req_s = s; req_m = m; req_carry = c; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_s = '0; req_m = 1'b0; req_carry = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_carry, rsp_equal} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: ready/valid/carry/equal=%b required 0000", {req_ready, rsp_valid, rsp_carry, rsp_equal});
    end
    checks++;
    if (rsp_f !== '0) begin failures++; $display("FAIL reset_f: got %h required 0", rsp_f); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b required 1", req_ready); end
    checks++;
    if ({alu_s, alu_m, alu_carry, alu_a, alu_b} !== 14'b0) begin
      failures++;
      $display("FAIL idle_alu: got %h required 0", {alu_s, alu_m, alu_carry, alu_a, alu_b});
    end
  endtask

  task automatic test_add();
    int lat;
    send_req(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF);
    wait_rsp(lat);
    checks++;
    if (lat != NIBBLES) begin failures++; $display("FAIL add_latency: got %0d required %0d", lat, NIBBLES); end
    checks++;
    if (rsp_f !== 16'h2233) begin failures++; $display("FAIL add_f: got %h required 2233", rsp_f); end
    checks++;
    if (rsp_carry !== 1'b0) begin failures++; $display("FAIL add_carry: got %b required 0", rsp_carry); end
    consume();
  endtask

  task automatic test_carry_chain();
    int lat;
    send_req(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    wait_rsp(lat);
    checks++;
    if ({rsp_carry, rsp_f} !== 17'h10000) begin
      failures++; $display("FAIL chain_b1: got carry=%b f=%h required carry=1 f=0000", rsp_carry, rsp_f);
    end
    consume();
    send_req(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    wait_rsp(lat);
    checks++;
    if ({rsp_carry, rsp_f} !== 17'h10000) begin
      failures++; $display("FAIL chain_cin: got carry=%b f=%h required carry=1 f=0000", rsp_carry, rsp_f);
    end
    consume();
  endtask

  task automatic test_logic();
    int lat;
    send_req(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    wait_rsp(lat);
    checks++;
    if (rsp_f !== 16'h0FF0) begin failures++; $display("FAIL logic_f: got %h required 0ff0", rsp_f); end
    checks++;
    if (rsp_carry !== 1'b0) begin failures++; $display("FAIL logic_carry: got %b required 0", rsp_carry); end
    consume();
  endtask

  task automatic test_equality();
    int lat;
    send_req(4'b0110, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A);
    wait_rsp(lat);
    checks++;
    if (rsp_equal !== 1'b1) begin failures++; $display("FAIL equal_same: got %b required 1", rsp_equal); end
    consume();
    send_req(4'b0110, 1'b0, 1'b0, 16'h5A5B, 16'h5A5A);
    wait_rsp(lat);
    checks++;
    if (rsp_equal !== 1'b0) begin failures++; $display("FAIL equal_diff: got %b required 0", rsp_equal); end
    consume();
  endtask

  task automatic test_random(input int iters);
    int lat;
    logic [3:0] s; logic m, c; logic [W-1:0] a, b; logic [W:0] e;
    for (int i = 0; i < iters; i++) begin
      s = 4'($urandom); m = 1'($urandom); c = 1'($urandom);
      a = W'($urandom); b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      e = model(s, m, c, a, b);
      send_req(s, m, c, a, b);
      wait_rsp(lat);
      checks++;
      if ({rsp_carry, rsp_f} !== e) begin
        failures++;
        $display("FAIL rand_result s=%h m=%b c=%b a=%h b=%h: got %h required %h", s, m, c, a, b, {rsp_carry, rsp_f}, e);
      end
      checks++;
      if (rsp_equal !== (e[W-1:0] == {W{1'b1}})) begin
        failures++; $display("FAIL rand_equal: got %b required %b", rsp_equal, e[W-1:0] == {W{1'b1}});
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W:0] e1, e2;
    e1 = model(4'b1001, 1'b0, 1'b0, 16'h1111, 16'h2222);
    e2 = model(4'b0110, 1'b0, 1'b1, 16'h9000, 16'h1234);
    send_req(4'b1001, 1'b0, 1'b0, 16'h1111, 16'h2222);
    wait_rsp(lat);
    req_s = 4'b0110; req_m = 1'b0; req_carry = 1'b1; req_a = 16'h9000; req_b = 16'h1234; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, req_ready, rsp_carry, rsp_f} !== {1'b1, 1'b0, e1}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b result=%h required valid=1 ready=0 result=%h",
                 i, rsp_valid, req_ready, {rsp_carry, rsp_f}, e1);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    send_req(4'b0110, 1'b0, 1'b1, 16'h9000, 16'h1234);
    rsp_ready = 1'b0;
    wait_rsp(lat);
    checks++;
    if ({rsp_carry, rsp_f} !== e2) begin
      failures++; $display("FAIL bp_second: got %h required %h", {rsp_carry, rsp_f}, e2);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    logic [W:0] e;
    send_req(4'b1001, 1'b0, 1'b0, 16'hABCD, 16'h1357);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_carry, rsp_equal, rsp_f} !== '0) begin
      failures++; $display("FAIL midrst_rsp: got %h required 0", {req_ready, rsp_valid, rsp_carry, rsp_equal, rsp_f});
    end
    checks++;
    if ({alu_s, alu_m, alu_carry, alu_a, alu_b} !== 14'b0) begin
      failures++; $display("FAIL midrst_alu: got %h required 0", {alu_s, alu_m, alu_carry, alu_a, alu_b});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_ghost: got %0d responses required 0", seen); end
    e = model(4'b0110, 1'b0, 1'b1, 16'h8421, 16'h1248);
    send_req(4'b0110, 1'b0, 1'b1, 16'h8421, 16'h1248);
    wait_rsp(lat);
    checks++;
    if ({rsp_carry, rsp_f} !== e) begin
      failures++; $display("FAIL midrst_next: got %h required %h", {rsp_carry, rsp_f}, e);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] gotq[$];
    int acc_t[$];
    int nacc = 0;
    logic hs;
    rsp_ready = 1'b1;
    req_s = 4'($urandom); req_m = 1'($urandom); req_carry = 1'($urandom);
    req_a = W'($urandom); req_b = W'($urandom); req_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (rsp_valid) gotq.push_back({rsp_carry, rsp_f});
      hs = req_valid & req_ready;
      if (hs) begin
        acc_t.push_back(t);
        expq.push_back(model(req_s, req_m, req_carry, req_a, req_b));
      end
      @(posedge clk); #1;
      if (hs) begin
        nacc++;
        if (nacc < 4) begin
          req_s = 4'($urandom); req_m = 1'($urandom); req_carry = 1'($urandom);
          req_a = W'($urandom); req_b = W'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (acc_t.size() != 4 || gotq.size() != 4) begin
      failures++; $display("FAIL b2b_count: accepts=%0d responses=%0d required 4 and 4", acc_t.size(), gotq.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      checks++;
      if (acc_t[i] - acc_t[i-1] != EXP_PERIOD) begin
        failures++; $display("FAIL b2b_period %0d: got %0d required %0d", i, acc_t[i] - acc_t[i-1], EXP_PERIOD);
      end
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        failures++; $display("FAIL b2b_result %0d: got %h required %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_logic();
    test_equality();
    test_random(40);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
